imem_byte_responder: RTL and testbench

Memory-side responder for the instruction-fetch read interface. Accepts a 32-bit word read request (`read_req`, `read_addr`), fetches the four bytes from a byte-wide, synchronous-read instruction memory, assembles them little-endian, and returns the word on `read_data` with a one-cycle `read_finish` pulse. Sits between the fetch-side ROM front end, which drives `read_addr` and waits on `read_finish`/`read_data`, and the byte-organised instruction memory array.

---
 rtl/imem_byte_responder_pkg.sv | 12 +
 rtl/imem_byte_responder.sv | 67 ++++++
 tb/tb_imem_byte_responder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_byte_responder_pkg.sv
// imem_byte_responder_pkg: shared state encodings and level constants for the byte responder
package imem_byte_responder_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_t;
  localparam logic avail = 1'b1;
  localparam logic unavail = 1'b0;
  localparam logic [31:0] zeroword = 32'h0000_0000;
endpackage

// File: rtl/imem_byte_responder.sv
// imem_byte_responder: fetches a 32-bit word as four little-endian bytes from a byte-wide sync-read memory
//   clk/rst_n               clock, async active-low reset
//   read_req/read_addr      word request from the fetch side (addr[1:0] ignored)
//   read_finish/read_data   one-cycle completion pulse with the assembled word
//   read_busy               high in READ and TAIL
//   mem_rd_en/mem_addr      byte read strobe and address to the memory
//   mem_rdata               byte returned one cycle after mem_rd_en
module imem_byte_responder
  import imem_byte_responder_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_req,
  input  logic [31:0]       read_addr,
  output logic              read_finish,
  output logic [31:0]       read_data,
  output logic              read_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, cap_cnt_q, cap_cnt_d;
  logic cap_vld_q, cap_vld_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic accept;
  logic unused_addr;
  assign unused_addr = ^{read_addr[31:ADDR_W], read_addr[1:0]};
  always_comb begin
    accept = (state_q == S_IDLE || state_q == S_DONE) && read_req;
    state_d = accept ? S_READ :
              state_q == S_READ ? (cnt_q == 2'd3 ? S_TAIL : S_READ) :
              state_q == S_TAIL ? S_DONE : S_IDLE;
    cnt_d = state_q == S_READ ? cnt_q + 2'd1 : 2'd0;
    // memory answers one cycle after the strobe, so the lane select trails cnt by one
    cap_vld_d = state_q == S_READ;
    cap_cnt_d = cnt_q;
    base_d = accept ? {read_addr[ADDR_W-1:2], 2'b00} : base_q;
    data_d = data_q;
    if (cap_vld_q) data_d[{cap_cnt_q, 3'b000} +: 8] = mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      cap_cnt_q <= 2'd0;
      cap_vld_q <= unavail;
      base_q    <= '0;
      data_q    <= zeroword;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_cnt_q <= cap_cnt_d;
      cap_vld_q <= cap_vld_d;
      base_q    <= base_d;
      data_q    <= data_d;
    end
  end
  assign read_finish = state_q == S_DONE ? avail : unavail;
  assign read_busy   = (state_q == S_READ || state_q == S_TAIL) ? avail : unavail;
  assign mem_rd_en   = state_q == S_READ ? avail : unavail;
  assign mem_addr    = state_q == S_READ ? (base_q | ADDR_W'(cnt_q)) : '0;
  assign read_data   = data_q;
endmodule

// File: tb/tb_imem_byte_responder.sv
// tb_imem_byte_responder: randomized self-checking bench against a word-level memory model
module tb_imem_byte_responder;
  logic clk = 1'b0;
  logic rst_n;
  logic read_req;
  logic [31:0] read_addr;
  logic read_finish;
  logic [31:0] read_data;
  logic read_busy;
  logic mem_rd_en;
  logic [12:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem [0:8191];
  int total = 0;
  int bad = 0;
  int rd_pulses = 0;

  imem_byte_responder #(.ADDR_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .read_req(read_req), .read_addr(read_addr),
    .read_finish(read_finish), .read_data(read_data), .read_busy(read_busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_pulses <= rd_pulses + 1;
    end
  end

  function automatic logic [12:0] word_base(input logic [31:0] a);
    return {a[12:2], 2'b00};
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [12:0] b;
    b = word_base(a);
    return {mem[b + 13'd3], mem[b + 13'd2], mem[b + 13'd1], mem[b]};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    read_req = 1'b1;
    read_addr = 32'h100;
    repeat (5) cyc();
    total++;
    if ({read_finish, read_busy, mem_rd_en} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {read_finish, read_busy, mem_rd_en});
    end
    total++;
    if (mem_addr !== 13'h0 || read_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_values got addr=%h data=%h want 0/0", mem_addr, read_data);
    end
    total++;
    if (rd_pulses !== 0) begin
      bad++;
      $display("FAIL reset_rd_en got pulses=%0d want=0", rd_pulses);
    end
    read_req = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read(input string name, input logic [31:0] addr);
    logic [12:0] b;
    logic [31:0] w;
    b = word_base(addr);
    w = model_word(addr);
    read_addr = addr;
    read_req = 1'b1;
    cyc();
    read_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (mem_rd_en !== 1'b1 || mem_addr !== b + 13'(k) || read_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_issue%0d got en=%b addr=%h busy=%b want en=1 addr=%h busy=1",
                 name, k, mem_rd_en, mem_addr, read_busy, b + 13'(k));
      end
      cyc();
    end
    total++;
    if (mem_rd_en !== 1'b0 || read_busy !== 1'b1 || read_finish !== 1'b0) begin
      bad++;
      $display("FAIL %s_tail got en=%b busy=%b fin=%b want 0/1/0", name, mem_rd_en, read_busy, read_finish);
    end
    cyc();
    total++;
    if (read_finish !== 1'b1 || read_data !== w || read_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got fin=%b data=%h busy=%b want fin=1 data=%h busy=0",
               name, read_finish, read_data, read_busy, w);
    end
    cyc();
    total++;
    if (read_finish !== 1'b0 || read_data !== w) begin
      bad++;
      $display("FAIL %s_after got fin=%b data=%h want fin=0 data=%h", name, read_finish, read_data, w);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    read_addr = 32'h100;
    read_req = 1'b1;
    cyc();
    n = 1;
    while (!read_finish && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (read_finish !== 1'b1 || n !== 6 || read_data !== 32'h0050_0013) begin
      bad++;
      $display("FAIL b2b_first got fin=%b lat=%0d data=%h want fin=1 lat=6 data=00500013", read_finish, n, read_data);
    end
    read_addr = 32'h104;
    cyc();
    n = 1;
    while (!read_finish && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (read_finish !== 1'b1 || n !== 6 || read_data !== 32'h0001_02B7) begin
      bad++;
      $display("FAIL b2b_second got fin=%b gap=%0d data=%h want fin=1 gap=6 data=000102b7", read_finish, n, read_data);
    end
    read_req = 1'b0;
    cyc();
    total++;
    if (read_finish !== 1'b0 || read_busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got fin=%b busy=%b en=%b want 0/0/0", read_finish, read_busy, mem_rd_en);
    end
  endtask

  task automatic test_addr_stable;
    read_addr = 32'h100;
    read_req = 1'b1;
    cyc();
    read_req = 1'b0;
    read_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (mem_addr !== 13'h100 + 13'(k)) begin
        bad++;
        $display("FAIL stable_addr%0d got=%h want=%h", k, mem_addr, 13'h100 + 13'(k));
      end
      cyc();
    end
    cyc();
    total++;
    if (read_finish !== 1'b1 || read_data !== 32'h0050_0013) begin
      bad++;
      $display("FAIL stable_data got fin=%b data=%h want fin=1 data=00500013", read_finish, read_data);
    end
    cyc();
  endtask

  task automatic test_reset_mid;
    int fins;
    int n;
    read_addr = 32'h104;
    read_req = 1'b1;
    cyc();
    read_req = 1'b0;
    cyc();
    cyc();
    total++;
    if (mem_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got en=%b want=1", mem_rd_en);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_rd_en !== 1'b0 || read_busy !== 1'b0 || read_data !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_drop got en=%b busy=%b data=%h want 0/0/0", mem_rd_en, read_busy, read_data);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    fins = 0;
    repeat (8) begin
      cyc();
      if (read_finish) fins++;
    end
    total++;
    if (fins !== 0 || read_busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet got finishes=%0d busy=%b want 0/0", fins, read_busy);
    end
    read_req = 1'b1;
    cyc();
    read_req = 1'b0;
    n = 1;
    while (!read_finish && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (read_finish !== 1'b1 || n !== 6 || read_data !== 32'h0001_02B7) begin
      bad++;
      $display("FAIL rstmid_after got fin=%b lat=%0d data=%h want fin=1 lat=6 data=000102b7", read_finish, n, read_data);
    end
    cyc();
  endtask

  task automatic test_random;
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] w;
    logic [12:0] b;
    prev = read_data;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      w = model_word(a);
      b = word_base(a);
      read_addr = a;
      read_req = 1'b1;
      cyc();
      read_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (mem_rd_en !== 1'b1 || mem_addr !== b + 13'(k)) begin
          bad++;
          $display("FAIL rand%0d_issue%0d got en=%b addr=%h want en=1 addr=%h", i, k, mem_rd_en, mem_addr, b + 13'(k));
        end
        if (k == 1) begin
          total++;
          if (read_data !== prev) begin
            bad++;
            $display("FAIL rand%0d_hold got=%h want=%h", i, read_data, prev);
          end
        end
        if (k == 2) begin
          total++;
          if (read_data !== {prev[31:8], w[7:0]}) begin
            bad++;
            $display("FAIL rand%0d_lane0 got=%h want=%h", i, read_data, {prev[31:8], w[7:0]});
          end
        end
        cyc();
      end
      cyc();
      total++;
      if (read_finish !== 1'b1 || read_data !== w) begin
        bad++;
        $display("FAIL rand%0d_done got fin=%b data=%h want fin=1 data=%h", i, read_finish, read_data, w);
      end
      prev = w;
      repeat ($urandom_range(0, 3)) cyc();
    end
    cyc();
  endtask

  initial begin
    read_req = 1'b0;
    read_addr = 32'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h100] = 8'h13; mem[13'h101] = 8'h00; mem[13'h102] = 8'h50; mem[13'h103] = 8'h00;
    mem[13'h104] = 8'hB7; mem[13'h105] = 8'h02; mem[13'h106] = 8'h01; mem[13'h107] = 8'h00;
    #2;
    test_reset();
    test_single_read("single", 32'h0000_0100);
    test_single_read("wrap", 32'h8000_2103);
    test_back_to_back();
    test_addr_stable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
